dsp_simd_addsub_acc: RTL and testbench
======================================

// Module: dsp_simd_addsub_acc
// PURPOSE
//  Parametrised SIMD adder/subtractor/accumulator: LANES independent unsigned lanes of LANE_W bits
//  share one control path. Per transaction it adds, subtracts, accumulates or loads.
//  Generalises the fixed two-lane 24-bit adder with lane count/width, subtract, per-lane accumulators,
//  sticky overflow and a valid-qualified pipeline. Sits in the DSP48E application datapath.
// PARAMETERS
//  LANES    2          number of independent lanes (>=1)
//  LANE_W   24         input operand width per lane
//  ACC_W    LANE_W+8   result/accumulator width per lane (>= LANE_W+2)
//  LATENCY  2          IN_VALID -> OUT_VALID cycles (>=1)
// PORTS
//  CLK        in   1              clock, all logic on rising edge
//  RST        in   1              synchronous, active-high reset
//  IN_VALID   in   1              transaction strobe; OP/A/B sampled when high
//  OP         in   2              00 ADD, 01 SUB, 10 ACC, 11 LOAD
//  A          in   LANES*LANE_W   lane k operand in bits [k*LANE_W +: LANE_W]
//  B          in   LANES*LANE_W   lane k operand, same packing
//  OUT_VALID  out  1              OUT carries a new result
//  OUT        out  LANES*ACC_W    lane k result in bits [k*ACC_W +: ACC_W]
//  OVF        out  LANES          per-lane sticky accumulator overflow
// BEHAVIOUR
//  - Reset (any cycle, incl. mid-transaction): OUT=0, OUT_VALID=0, OVF=0, accumulators=0,
//    all pipeline valid bits cleared; in-flight transactions discarded. RST wins over IN_VALID.
//  - Operands unsigned. Per lane, on IN_VALID, in stage 1:
//    ADD : r = {0,A}+{0,B} (LANE_W+1 bits), zero-extended to ACC_W; acc, OVF unchanged.
//    SUB : r = {0,A}-{0,B} as LANE_W+1-bit two's complement, sign-extended to ACC_W; acc, OVF unchanged.
//    ACC : acc <= acc + A + B mod 2^ACC_W; OVF[k] <= 1 if carry out of ACC_W; r = new acc.
//    LOAD: acc <= A + B; OVF[k] <= 0; r = new acc.
//  - Stage 1 computes r and updates acc in the same edge; back-to-back ACC/LOAD on consecutive
//    cycles chain with no bubble and no hazard.
//  - r travels LATENCY-1 further register stages with its valid bit; OUT_VALID=1 exactly
//    LATENCY cycles after the IN_VALID cycle, one pulse per transaction.
//  - IN_VALID=0: no acc/OVF change; OP/A/B ignored; pipeline shifts a bubble.
//  - OUT holds last valid result while OUT_VALID=0 (output register enabled by valid only).
//  - OVF is sticky: cleared only by RST or LOAD on that lane. Lanes never interact (no carry
//    between lanes).
//  - No backpressure; throughput one transaction per cycle.
// STRUCTURE
//  - Shared package dsp_simd_pkg: OP_ADD/OP_SUB/OP_ACC/OP_LOAD 2-bit constants.
//  - Sub-module dsp_simd_lane: one lane's stage-1 arithmetic, accumulator, OVF bit and
//    result pipeline (data only); top generates LANES instances and owns the shared
//    valid shift register and OUT/OUT_VALID packing.
// TESTING  (defaults LANES=2, LANE_W=24, ACC_W=32, LATENCY=2)
//  1. ADD, lane0 A=8299999 B=8288888, lane1 A=B=8388607 -> 2 cycles later OUT_VALID=1,
//     lane0 0x00FD2057, lane1 0x00FFFFFE; OVF=00.
//  2. SUB lane0 A=10 B=1115, lane1 A=1115 B=10 -> lane0 0xFFFFFBAF, lane1 0x00000451.
//  3. LOAD A=B=0 then 128 consecutive ACC with A=B=0xFFFFFF on lane1 only (lane0 A=B=0) ->
//     last lane1 0xFFFFFF00 OVF=00; 129th ACC -> 0x01FFFEFE, OVF=10; lane0 stays 0, OVF[0]=0.
//  4. After 3, ACC with IN_VALID gaps (1,0,0,1) -> only 2 OUT_VALID pulses, OVF[1] stays 1,
//     OUT holds between pulses; then LOAD A=5 B=7 -> 0x0000000C, OVF[1]=0.
//  5. Reset mid-flight: IN_VALID ACC then RST next cycle -> no OUT_VALID pulse, OUT=0,
//     next ACC A=1 B=1 returns 0x00000002.
//  6. Parameter sweep LANES=4, LANE_W=16, LATENCY=1/3 -> random ops vs reference model,
//     latency and lane packing checked every cycle.

Source files
------------

// File: rtl/dsp_simd_pkg.sv
// rtl/dsp_simd_pkg.sv - shared opcode constants for the SIMD add/sub/accumulate datapath
package dsp_simd_pkg;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_ACC  = 2'b10;
  localparam logic [1:0] OP_LOAD = 2'b11;

endpackage

// File: rtl/dsp_simd_addsub_acc_if.sv
// rtl/dsp_simd_addsub_acc_if.sv - transaction/result bundle between a driver and the SIMD datapath
interface dsp_simd_addsub_acc_if #(
  parameter int LANES  = 2,
  parameter int LANE_W = 24,
  parameter int ACC_W  = LANE_W + 8
);

  logic                    in_valid;
  logic [1:0]              op;
  logic [LANES*LANE_W-1:0] a;
  logic [LANES*LANE_W-1:0] b;
  logic                    out_valid;
  logic [LANES*ACC_W-1:0]  out;
  logic [LANES-1:0]        ovf;

  modport master (
    output in_valid, op, a, b,
    input  out_valid, out, ovf
  );

  modport slave (
    input  in_valid, op, a, b,
    output out_valid, out, ovf
  );

endinterface

// File: rtl/dsp_simd_lane.sv
// rtl/dsp_simd_lane.sv - one lane: stage-1 arithmetic, accumulator, sticky overflow, result pipeline
module dsp_simd_lane
  import dsp_simd_pkg::*;
#(
  parameter int LANE_W  = 24,
  parameter int ACC_W   = LANE_W + 8,
  parameter int LATENCY = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [LATENCY-1:0] stage_en,
  input  logic [1:0]         op,
  input  logic [LANE_W-1:0]  a,
  input  logic [LANE_W-1:0]  b,
  output logic [ACC_W-1:0]   res,
  output logic               ovf
);

  localparam int EXT_W = ACC_W - LANE_W - 1;

  logic [LANE_W:0]  sum_w;
  logic [LANE_W:0]  diff_w;
  logic [ACC_W:0]   acc_sum_w;
  logic [ACC_W-1:0] r_w;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic [ACC_W-1:0] pipe_q [LATENCY];
  logic [ACC_W-1:0] pipe_d [LATENCY];

  always_comb begin
    sum_w     = {1'b0, a} + {1'b0, b};
    diff_w    = {1'b0, a} - {1'b0, b};
    acc_sum_w = {1'b0, acc_q} + {{(EXT_W + 1){1'b0}}, sum_w};
    r_w       = '0;
    acc_d     = acc_q;
    ovf_d     = ovf_q;
    if (stage_en[0]) begin
      case (op)
        OP_ADD: r_w = {{EXT_W{1'b0}}, sum_w};
        OP_SUB: r_w = {{EXT_W{diff_w[LANE_W]}}, diff_w};
        OP_ACC: begin
          acc_d = acc_sum_w[ACC_W-1:0];
          ovf_d = ovf_q | acc_sum_w[ACC_W];
          r_w   = acc_sum_w[ACC_W-1:0];
        end
        default: begin
          acc_d = {{EXT_W{1'b0}}, sum_w};
          ovf_d = 1'b0;
          r_w   = {{EXT_W{1'b0}}, sum_w};
        end
      endcase
    end
  end

  // Each stage only loads when its valid bit moves in, so the last stage holds the last result.
  always_comb begin
    for (int i = 0; i < LATENCY; i++) begin
      pipe_d[i] = pipe_q[i];
    end
    if (stage_en[0]) begin
      pipe_d[0] = r_w;
    end
    for (int i = 1; i < LATENCY; i++) begin
      if (stage_en[i]) begin
        pipe_d[i] = pipe_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
      for (int i = 0; i < LATENCY; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      acc_q <= acc_d;
      ovf_q <= ovf_d;
      for (int i = 0; i < LATENCY; i++) begin
        pipe_q[i] <= pipe_d[i];
      end
    end
  end

  assign res = pipe_q[LATENCY-1];
  assign ovf = ovf_q;

endmodule

// File: rtl/dsp_simd_addsub_acc.sv
// rtl/dsp_simd_addsub_acc.sv - LANES-wide unsigned add/sub/accumulate/load with shared valid pipeline
module dsp_simd_addsub_acc
  import dsp_simd_pkg::*;
#(
  parameter int LANES   = 2,
  parameter int LANE_W  = 24,
  parameter int ACC_W   = LANE_W + 8,
  parameter int LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  dsp_simd_addsub_acc_if.slave bus
);

  logic [LATENCY-1:0]     vld_q, vld_d;
  logic [LANES*ACC_W-1:0] out_w;
  logic [LANES-1:0]       ovf_w;

  // vld_d doubles as the per-stage load enable handed to every lane.
  always_comb begin
    vld_d[0] = bus.in_valid;
    for (int i = 1; i < LATENCY; i++) begin
      vld_d[i] = vld_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
    end else begin
      vld_q <= vld_d;
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    dsp_simd_lane #(
      .LANE_W  (LANE_W),
      .ACC_W   (ACC_W),
      .LATENCY (LATENCY)
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .stage_en (vld_d),
      .op       (bus.op),
      .a        (bus.a[k*LANE_W +: LANE_W]),
      .b        (bus.b[k*LANE_W +: LANE_W]),
      .res      (out_w[k*ACC_W +: ACC_W]),
      .ovf      (ovf_w[k])
    );
  end

  assign bus.out       = out_w;
  assign bus.out_valid = vld_q[LATENCY-1];
  assign bus.ovf       = ovf_w;

endmodule

// File: tb/tb_dsp_simd_addsub_acc.sv
// tb/tb_dsp_simd_addsub_acc.sv - directed checks on the default build plus a 4-lane latency 1/3 sweep
module tb_dsp_simd_addsub_acc;

  localparam logic [1:0] T_ADD  = 2'b00;
  localparam logic [1:0] T_SUB  = 2'b01;
  localparam logic [1:0] T_ACC  = 2'b10;
  localparam logic [1:0] T_LOAD = 2'b11;
  localparam int         NS     = 500;
  localparam longint unsigned MASK24 = 64'hFFFFFF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   pulses;

  logic [63:0]     sa, sb;
  logic [95:0]     rtmp, hold1, hold3;
  logic [95:0]     mr [NS];
  bit              mv [NS];
  bit              sv, v3;
  logic [1:0]      sop;
  logic [3:0]      movf;
  longint unsigned macc [4];
  longint unsigned la, lb, t, rl;

  always #5 clk = ~clk;

  dsp_simd_addsub_acc_if #(.LANES(2), .LANE_W(24), .ACC_W(32)) m_if ();
  dsp_simd_addsub_acc_if #(.LANES(4), .LANE_W(16), .ACC_W(24)) s1_if ();
  dsp_simd_addsub_acc_if #(.LANES(4), .LANE_W(16), .ACC_W(24)) s3_if ();

  dsp_simd_addsub_acc #(.LANES(2), .LANE_W(24), .ACC_W(32), .LATENCY(2)) u_dut (
    .clk (clk), .rst (rst), .bus (m_if)
  );
  dsp_simd_addsub_acc #(.LANES(4), .LANE_W(16), .ACC_W(24), .LATENCY(1)) u_dut_l1 (
    .clk (clk), .rst (rst), .bus (s1_if)
  );
  dsp_simd_addsub_acc #(.LANES(4), .LANE_W(16), .ACC_W(24), .LATENCY(3)) u_dut_l3 (
    .clk (clk), .rst (rst), .bus (s3_if)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic v, input logic [1:0] o, input logic [47:0] av, input logic [47:0] bv);
    m_if.in_valid = v;
    m_if.op       = o;
    m_if.a        = av;
    m_if.b        = bv;
    @(negedge clk);
  endtask

  task automatic sdrive(input logic v, input logic [1:0] o, input logic [63:0] av, input logic [63:0] bv);
    s1_if.in_valid = v;  s1_if.op = o;  s1_if.a = av;  s1_if.b = bv;
    s3_if.in_valid = v;  s3_if.op = o;  s3_if.a = av;  s3_if.b = bv;
  endtask

  initial begin
    sdrive(1'b0, T_ADD, '0, '0);
    m_if.in_valid = 1'b0; m_if.op = T_ADD; m_if.a = '0; m_if.b = '0;
    @(negedge clk);
    cyc(1'b0, T_ADD, 48'd0, 48'd0);
    chk("rst_out_valid", m_if.out_valid, 1'b0);
    chk("rst_out", m_if.out, 64'd0);
    chk("rst_ovf", m_if.ovf, 2'b00);
    rst = 1'b0;

    cyc(1'b1, T_ADD, {24'd8388607, 24'd8299999}, {24'd8388607, 24'd8288888});
    chk("add_lat1_valid", m_if.out_valid, 1'b0);
    cyc(1'b0, T_ADD, 48'd0, 48'd0);
    chk("add_valid", m_if.out_valid, 1'b1);
    chk("add_out", m_if.out, {32'h00FFFFFE, 32'h00FD2057});
    chk("add_ovf", m_if.ovf, 2'b00);
    cyc(1'b0, T_ADD, 48'd0, 48'd0);
    chk("add_pulse_end", m_if.out_valid, 1'b0);
    chk("add_hold", m_if.out, {32'h00FFFFFE, 32'h00FD2057});

    cyc(1'b1, T_SUB, {24'd1115, 24'd10}, {24'd10, 24'd1115});
    cyc(1'b0, T_ADD, 48'd0, 48'd0);
    chk("sub_valid", m_if.out_valid, 1'b1);
    chk("sub_out", m_if.out, {32'h00000451, 32'hFFFFFBAF});

    cyc(1'b1, T_LOAD, 48'd0, 48'd0);
    for (int i = 0; i < 128; i++) begin
      cyc(1'b1, T_ACC, {24'hFFFFFF, 24'd0}, {24'hFFFFFF, 24'd0});
    end
    chk("acc128_ovf", m_if.ovf, 2'b00);
    cyc(1'b0, T_ADD, 48'd0, 48'd0);
    chk("acc128_out", m_if.out, {32'hFFFFFF00, 32'h0});
    cyc(1'b1, T_ACC, {24'hFFFFFF, 24'd0}, {24'hFFFFFF, 24'd0});
    chk("acc129_ovf", m_if.ovf, 2'b10);
    cyc(1'b0, T_ADD, 48'd0, 48'd0);
    chk("acc129_valid", m_if.out_valid, 1'b1);
    chk("acc129_out", m_if.out, {32'h01FFFEFE, 32'h0});

    pulses = 0;
    cyc(1'b1, T_ACC, {24'd1, 24'd0}, {24'd1, 24'd0});
    pulses += int'(m_if.out_valid);
    cyc(1'b0, T_LOAD, 48'hFFFFFFFFFFFF, 48'hFFFFFFFFFFFF);
    pulses += int'(m_if.out_valid);
    chk("gap_out1", m_if.out, {32'h01FFFF00, 32'h0});
    cyc(1'b0, T_LOAD, 48'hFFFFFFFFFFFF, 48'hFFFFFFFFFFFF);
    pulses += int'(m_if.out_valid);
    chk("gap_hold", m_if.out, {32'h01FFFF00, 32'h0});
    chk("gap_hold_valid", m_if.out_valid, 1'b0);
    cyc(1'b1, T_ACC, {24'd1, 24'd0}, {24'd1, 24'd0});
    pulses += int'(m_if.out_valid);
    cyc(1'b0, T_ADD, 48'd0, 48'd0);
    pulses += int'(m_if.out_valid);
    chk("gap_out2", m_if.out, {32'h01FFFF02, 32'h0});
    cyc(1'b0, T_ADD, 48'd0, 48'd0);
    pulses += int'(m_if.out_valid);
    chk("gap_pulses", pulses, 2);
    chk("gap_ovf_sticky", m_if.ovf, 2'b10);

    cyc(1'b1, T_LOAD, {24'd5, 24'd5}, {24'd7, 24'd7});
    chk("load_ovf_clr", m_if.ovf, 2'b00);
    cyc(1'b0, T_ADD, 48'd0, 48'd0);
    chk("load_out", m_if.out, {32'h0000000C, 32'h0000000C});

    cyc(1'b1, T_ACC, {24'd3, 24'd3}, {24'd3, 24'd3});
    rst = 1'b1;
    cyc(1'b0, T_ADD, 48'd0, 48'd0);
    rst = 1'b0;
    chk("midrst_valid", m_if.out_valid, 1'b0);
    chk("midrst_out", m_if.out, 64'd0);
    chk("midrst_ovf", m_if.ovf, 2'b00);
    cyc(1'b0, T_ADD, 48'd0, 48'd0);
    chk("midrst_no_pulse", m_if.out_valid, 1'b0);
    cyc(1'b1, T_ACC, {24'd1, 24'd1}, {24'd1, 24'd1});
    cyc(1'b0, T_ADD, 48'd0, 48'd0);
    chk("postrst_valid", m_if.out_valid, 1'b1);
    chk("postrst_out", m_if.out, {32'h2, 32'h2});

    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    hold1 = '0;
    hold3 = '0;
    movf  = '0;
    for (int k = 0; k < 4; k++) macc[k] = 0;
    for (int n = 0; n < NS; n++) begin
      if (n % 250 == 0) begin
        sv  = 1'b1;
        sop = T_LOAD;
      end else begin
        sv = ($urandom_range(0, 7) != 0);
        case ($urandom_range(0, 7))
          0:       sop = T_ADD;
          1:       sop = T_SUB;
          default: sop = T_ACC;
        endcase
      end
      for (int k = 0; k < 4; k++) begin
        sa[k*16 +: 16] = 16'hFFFF - 16'($urandom_range(0, 4095));
        sb[k*16 +: 16] = 16'($urandom_range(0, 65535));
      end
      rtmp = '0;
      if (sv) begin
        for (int k = 0; k < 4; k++) begin
          la = longint'(sa[k*16 +: 16]);
          lb = longint'(sb[k*16 +: 16]);
          case (sop)
            T_ADD: rl = la + lb;
            T_SUB: rl = (la - lb) & MASK24;
            T_ACC: begin
              t = macc[k] + la + lb;
              if (t > MASK24) movf[k] = 1'b1;
              macc[k] = t & MASK24;
              rl = macc[k];
            end
            default: begin
              macc[k] = la + lb;
              movf[k] = 1'b0;
              rl = macc[k];
            end
          endcase
          rtmp[k*24 +: 24] = rl[23:0];
        end
      end
      mv[n] = sv;
      mr[n] = rtmp;
      sdrive(sv, sop, sa, sb);
      @(negedge clk);
      if (mv[n]) hold1 = mr[n];
      chk("sw_l1_valid", s1_if.out_valid, mv[n]);
      chk("sw_l1_out", s1_if.out, hold1);
      chk("sw_l1_ovf", s1_if.ovf, movf);
      v3 = (n >= 2) ? mv[n-2] : 1'b0;
      if (v3) hold3 = mr[n-2];
      chk("sw_l3_valid", s3_if.out_valid, v3);
      chk("sw_l3_out", s3_if.out, hold3);
      chk("sw_l3_ovf", s3_if.ovf, movf);
    end
    sdrive(1'b0, T_ADD, '0, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
